// File: rtl/xbar_bank_pop_ctrl_pkg.sv
// Shared types and sizing for the xbar bank read-side pop controller.
package xbar_bank_pop_ctrl_pkg;

    localparam int XBAR_NUM_CH = 3;
    localparam int XBAR_PTR_W  = 3;
    localparam int XBAR_DATA_W = 64;
    localparam int XBAR_CH_W   = $clog2(XBAR_NUM_CH);

    typedef enum logic [1:0] {
        POP_IDLE,
        POP_REQ,
        POP_DONE
    } xbar_pop_st_e;

    typedef struct packed {
        logic [XBAR_DATA_W-1:0] data;
        logic [XBAR_CH_W-1:0]   ch;
        logic [XBAR_PTR_W-1:0]  ptr;
    } xbar_bank_req_t;

endpackage

// File: rtl/xbar_rr_arb.sv
// Round-robin arbiter with one-hot grant; priority rotates to the channel after
// the winner whenever adv is asserted.
module xbar_rr_arb #(
    parameter int NUM_CH = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              adv,
    output logic [NUM_CH-1:0] grant
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W:0]   idx;
    logic             found;

    always_comb begin
        grant   = '0;
        win_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = {1'b0, rr_ptr} + (IDX_W+1)'(i);
            if (idx >= (IDX_W+1)'(NUM_CH)) begin
                idx = idx - (IDX_W+1)'(NUM_CH);
            end
            if (!found && req[idx[IDX_W-1:0]]) begin
                grant[idx[IDX_W-1:0]] = 1'b1;
                win_idx               = idx[IDX_W-1:0];
                found                 = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (adv && found) begin
            rr_ptr <= (win_idx == IDX_W'(NUM_CH-1)) ? '0 : win_idx + 1'b1;
        end
    end

endmodule

// File: rtl/xbar_bank_pop_ctrl.sv
// Per-bank pop controller: issues each channel's head-entry part to the bank and
// flags consumption. Optional perf counters under XBAR_BANK_POP_PERF_EN.
module xbar_bank_pop_ctrl
    import xbar_bank_pop_ctrl_pkg::*;
#(
    parameter int NUM_CH = XBAR_NUM_CH,
    parameter int PTR_W  = XBAR_PTR_W,
    parameter int DATA_W = XBAR_DATA_W
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CH-1:0][PTR_W-1:0]   ch_w_ptr,
    input  logic [NUM_CH-1:0][PTR_W-1:0]   ch_r_ptr,
    input  logic [NUM_CH-1:0]              ch_head_hit,
    input  logic [NUM_CH-1:0][DATA_W-1:0]  ch_head_data,
    output logic [NUM_CH-1:0]              ch_last_entry_already_pop,
    output logic                           bank_req_valid,
    input  logic                           bank_req_ready,
    output logic [DATA_W-1:0]              bank_req_data,
    output logic [$clog2(NUM_CH)-1:0]      bank_req_ch,
    output logic [PTR_W-1:0]               bank_req_ptr
`ifdef XBAR_BANK_POP_PERF_EN
    ,
    output logic [15:0]                    stall_cnt,
    output logic [NUM_CH-1:0][15:0]        wait_cnt
`endif
);

    localparam int CH_W = $clog2(NUM_CH);

    xbar_pop_st_e     st     [NUM_CH];
    xbar_pop_st_e     st_nxt [NUM_CH];
    logic [PTR_W-1:0] done_ptr [NUM_CH];

    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] loaded;
    logic [NUM_CH-1:0] hs_ch;
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] grant;
    logic [CH_W-1:0]   win;
    logic              handshake;
    logic              load;

    xbar_bank_req_t out_p1;
    logic           vld_p1;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign handshake = vld_p1 && bank_req_ready;
    // A new winner may load whenever the output slot is empty or draining this cycle.
    assign load      = (|req) && (!vld_p1 || bank_req_ready);

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            pending[c] = (ch_w_ptr[c] != ch_r_ptr[c]);
            loaded[c]  = vld_p1 && (out_p1.ch == XBAR_CH_W'(c));
            hs_ch[c]   = handshake && loaded[c];
            req[c]     = ((st[c] == POP_REQ) && !loaded[c]) ||
                         ((st[c] == POP_IDLE) && pending[c] && ch_head_hit[c]);
            st_nxt[c]  = st[c];
            case (st[c])
                POP_IDLE: if (pending[c] && ch_head_hit[c]) st_nxt[c] = POP_REQ;
                POP_REQ:  if (hs_ch[c]) st_nxt[c] = POP_DONE;
                POP_DONE: if (ch_r_ptr[c] != done_ptr[c]) st_nxt[c] = POP_IDLE;
                default:  st_nxt[c] = POP_IDLE;
            endcase
            // The ptr match drops the flag in the same cycle r_ptr moves on.
            ch_last_entry_already_pop[c] =
                ((st[c] == POP_DONE) && (ch_r_ptr[c] == done_ptr[c])) ||
                ((st[c] == POP_IDLE) && pending[c] && !ch_head_hit[c]);
        end
    end

    always_comb begin
        win = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (grant[c]) win = CH_W'(c);
        end
    end

    xbar_rr_arb #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .adv   (load),
        .grant (grant)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) st[c] <= POP_IDLE;
        end else begin
            for (int c = 0; c < NUM_CH; c++) st[c] <= st_nxt[c];
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (hs_ch[c]) done_ptr[c] <= ch_r_ptr[c];
        end
    end

    // Stage p1: output request register
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            out_p1 <= '0;
        end else if (load) begin
            vld_p1      <= 1'b1;
            out_p1.data <= XBAR_DATA_W'(ch_head_data[win]);
            out_p1.ch   <= XBAR_CH_W'(win);
            out_p1.ptr  <= XBAR_PTR_W'(ch_r_ptr[win]);
        end else if (bank_req_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign bank_req_valid = vld_p1;
    assign bank_req_data  = DATA_W'(out_p1.data);
    assign bank_req_ch    = CH_W'(out_p1.ch);
    assign bank_req_ptr   = PTR_W'(out_p1.ptr);

`ifdef XBAR_BANK_POP_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            wait_cnt  <= '0;
        end else begin
            if (vld_p1 && !bank_req_ready) stall_cnt <= sat_inc(stall_cnt);
            for (int c = 0; c < NUM_CH; c++) begin
                if ((st[c] == POP_REQ) && !loaded[c]) wait_cnt[c] <= sat_inc(wait_cnt[c]);
            end
        end
    end
`endif

endmodule

// File: tb/tb_xbar_bank_pop_ctrl.sv
// Directed self-checking bench for xbar_bank_pop_ctrl (default and perf builds).
module tb_xbar_bank_pop_ctrl;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0][2:0]  w_ptr;
    logic [2:0][2:0]  r_ptr;
    logic [2:0]       hit;
    logic [2:0][63:0] hdata;
    logic [2:0]       pop;
    logic             valid;
    logic             ready;
    logic [63:0]      data;
    logic [1:0]       ch;
    logic [2:0]       ptr;
`ifdef XBAR_BANK_POP_PERF_EN
    logic [15:0]      stall_cnt;
    logic [2:0][15:0] wait_cnt;
`endif

    int passed = 0;
    int total  = 0;
    int n;
    logic [2:0] rp;

    always #5 clk = ~clk;

    xbar_bank_pop_ctrl dut (
        .clk                       (clk),
        .rst                       (rst),
        .ch_w_ptr                  (w_ptr),
        .ch_r_ptr                  (r_ptr),
        .ch_head_hit               (hit),
        .ch_head_data              (hdata),
        .ch_last_entry_already_pop (pop),
        .bank_req_valid            (valid),
        .bank_req_ready            (ready),
        .bank_req_data             (data),
        .bank_req_ch               (ch),
`ifdef XBAR_BANK_POP_PERF_EN
        .stall_cnt                 (stall_cnt),
        .wait_cnt                  (wait_cnt),
`endif
        .bank_req_ptr              (ptr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1; w_ptr = '0; r_ptr = '0; hit = '0; hdata = '0; ready = 1'b1;
        tick(); tick(); settle();
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_pop",   64'(pop),   64'd0);
        chk("rst_data",  data,       64'd0);
        chk("rst_ch",    64'(ch),    64'd0);
        chk("rst_ptr",   64'(ptr),   64'd0);
        rst = 1'b0;

        // Contention: all three channels request together.
        w_ptr = {3'd1, 3'd1, 3'd1}; hit = 3'b111;
        hdata[0] = 64'hC0; hdata[1] = 64'hC1; hdata[2] = 64'hC2;
        settle();
        chk("rr_sel_cycle_valid", 64'(valid), 64'd0);
        for (int k = 0; k < 3; k++) begin
            tick(); settle();
            chk("rr_valid", 64'(valid), 64'd1);
            chk("rr_ch",    64'(ch),    64'(k));
            chk("rr_data",  data,       64'hC0 + 64'(k));
        end
        tick(); settle();
        chk("rr_drain_valid", 64'(valid), 64'd0);
        chk("rr_pop_all",     64'(pop),   64'h7);
        tick();
        r_ptr = {3'd1, 3'd1, 3'd1}; w_ptr = {3'd2, 3'd2, 3'd2};
        settle();
        chk("rr_pop_drop", 64'(pop), 64'd0);
        tick(); settle();
        chk("refill_sel_valid", 64'(valid), 64'd0);
        for (int k = 0; k < 3; k++) begin
            tick(); settle();
            chk("refill_ch",  64'(ch),  64'(k));
            chk("refill_ptr", 64'(ptr), 64'd1);
        end
        tick(); settle();
        chk("refill_pop_all", 64'(pop), 64'h7);
        r_ptr = {3'd2, 3'd2, 3'd2}; hit = '0;
        settle();
        chk("refill_pop_drop", 64'(pop), 64'd0);
        tick();
        r_ptr = '0; w_ptr = '0;

        // Single request with ready high.
        tick();
        w_ptr[0] = 3'd1; hit[0] = 1'b1; hdata[0] = 64'hA0;
        settle();
        chk("single_n_valid", 64'(valid), 64'd0);
        tick(); settle();
        chk("single_valid", 64'(valid), 64'd1);
        chk("single_ch",    64'(ch),    64'd0);
        chk("single_ptr",   64'(ptr),   64'd0);
        chk("single_data",  data,       64'hA0);
        chk("single_nopop", 64'(pop),   64'd0);
        tick(); settle();
        chk("single_pop",     64'(pop),   64'h1);
        chk("single_valid_lo", 64'(valid), 64'd0);
        tick(); settle();
        chk("single_pop_hold", 64'(pop), 64'h1);
        tick();
        r_ptr[0] = 3'd1; hit[0] = 1'b0;
        settle();
        chk("single_pop_drop", 64'(pop), 64'd0);
        tick(); settle();
        chk("single_idle_pop",   64'(pop),   64'd0);
        chk("single_idle_valid", 64'(valid), 64'd0);

        // No-hit entry: flag combinationally, never touch the bank.
        w_ptr[1] = 3'd1; hit[1] = 1'b0;
        settle();
        chk("nohit_pop",   64'(pop),   64'h2);
        chk("nohit_valid", 64'(valid), 64'd0);
        tick(); settle();
        chk("nohit_pop2",   64'(pop),   64'h2);
        chk("nohit_valid2", 64'(valid), 64'd0);
        tick();
        r_ptr[1] = 3'd1;
        settle();
        chk("nohit_pop_drop", 64'(pop), 64'd0);
        tick(); settle();
        chk("nohit_valid3", 64'(valid), 64'd0);

        // Backpressure: five stalled cycles.
        ready = 1'b0; w_ptr[0] = 3'd2; hit[0] = 1'b1; hdata[0] = 64'hDEAD_BEEF;
        for (int k = 0; k < 5; k++) begin
            tick(); settle();
            chk("bp_valid", 64'(valid), 64'd1);
            chk("bp_ch",    64'(ch),    64'd0);
            chk("bp_ptr",   64'(ptr),   64'd1);
            chk("bp_data",  data,       64'hDEAD_BEEF);
            chk("bp_nopop", 64'(pop),   64'd0);
        end
        tick();
        ready = 1'b1;
        settle();
        chk("bp_hs_valid", 64'(valid), 64'd1);
        tick(); settle();
        chk("bp_pop",      64'(pop),   64'h1);
        chk("bp_valid_lo", 64'(valid), 64'd0);
        tick();
        r_ptr[0] = 3'd2; hit[0] = 1'b0;
        settle();
        chk("bp_pop_drop", 64'(pop), 64'd0);

        // Wrap-around stream on ch2.
        rp = 3'd0; w_ptr[2] = 3'd1; hit[2] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            hdata[2] = 64'(k);
            n = 0;
            tick(); settle();
            while (!valid && n < 8) begin
                tick(); settle(); n++;
            end
            chk("wrap_valid", 64'(valid), 64'd1);
            chk("wrap_ptr",   64'(ptr),   64'(k % 8));
            chk("wrap_ch",    64'(ch),    64'd2);
            chk("wrap_data",  data,       64'(k));
            n = 0;
            tick(); settle();
            while (!pop[2] && n < 8) begin
                tick(); settle(); n++;
            end
            chk("wrap_pop", 64'(pop[2]), 64'd1);
            rp = rp + 3'd1;
            r_ptr[2] = rp;
            w_ptr[2] = (k < 9) ? rp + 3'd1 : rp;
            settle();
            chk("wrap_pop_drop", 64'(pop[2]), 64'd0);
            chk("wrap_no_dup",   64'(valid),  64'd0);
        end
        tick();
        hit[2] = 1'b0;

        // Mid-operation reset while stalled.
        tick();
        ready = 1'b0;
        w_ptr[0] = 3'd3; hit[0] = 1'b1; hdata[0] = 64'h55;
        w_ptr[2] = 3'd3; hit[2] = 1'b1; hdata[2] = 64'h77;
        w_ptr[1] = 3'd2; hit[1] = 1'b0;
        tick(); settle();
        chk("mrst_pre_valid", 64'(valid), 64'd1);
        chk("mrst_pre_ch",    64'(ch),    64'd0);
        chk("mrst_pre_pop",   64'(pop),   64'h2);
        tick();
        rst = 1'b1;
        settle();
        chk("mrst_hold_valid", 64'(valid), 64'd1);
        tick(); settle();
        chk("mrst_valid", 64'(valid), 64'd0);
        chk("mrst_data",  data,       64'd0);
        chk("mrst_ch",    64'(ch),    64'd0);
        chk("mrst_ptr",   64'(ptr),   64'd0);
        chk("mrst_pop",   64'(pop),   64'h2);
        rst = 1'b0;
        tick(); settle();
        chk("mrst_rr_valid", 64'(valid), 64'd1);
        chk("mrst_rr_ch",    64'(ch),    64'd0);
        chk("mrst_rr_ptr",   64'(ptr),   64'd2);
        chk("mrst_rr_data",  data,       64'h55);
        ready = 1'b1;
        tick(); settle();
        chk("mrst_b2b_valid", 64'(valid), 64'd1);
        chk("mrst_b2b_ch",    64'(ch),    64'd2);
        chk("mrst_b2b_ptr",   64'(ptr),   64'd2);
        chk("mrst_b2b_data",  data,       64'h77);
        tick(); tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/xbar_bank_pop_ctrl.md
Name: xbar_bank_pop_ctrl

Overview:
- Per-bank read-side controller for the xbar request buffers; one instance per bank (4 total).
- For each upstream channel, it reads the head entry selected by that channel's r_ptr/w_ptr pair and issues this bank's part of the entry to the bank port.
- It raises ch_last_entry_already_pop[c] once that part has been consumed. The pointer generator ANDs this flag across the 4 banks to advance r_ptr.
- Round-robin arbitration across channels onto one bank request port.

Parameters:
- NUM_CH, 3, number of upstream channels.
- PTR_W, 3, buffer pointer width (8 slots, max 7 used).
- DATA_W, 64, per-bank request payload width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock, synchronous, active-high.
- ch_w_ptr  in  NUM_CH x PTR_W  per-channel write pointer.
- ch_r_ptr  in  NUM_CH x PTR_W  per-channel read pointer.
- ch_head_hit  in  NUM_CH  head entry at r_ptr targets this bank.
- ch_head_data  in  NUM_CH x DATA_W  this bank's payload of the head entry.
- ch_last_entry_already_pop  out  NUM_CH  this bank has finished the head entry of channel c.
- bank_req_valid  out  1  request to bank.
- bank_req_ready  in  1  bank accepts.
- bank_req_data  out  DATA_W  payload.
- bank_req_ch  out  $clog2(NUM_CH)  source channel.
- bank_req_ptr  out  PTR_W  source slot (r_ptr at issue).

Behaviour:
- Channel c is pending when ch_w_ptr[c] != ch_r_ptr[c]. A pointer compare is used, not a count: the buffer holds at most 7 entries, so equal pointers always mean empty.
- Per-channel FSM has three states:
  - IDLE:
    - pending & hit -> REQ.
    - pending & ~hit -> pop flag asserted combinationally in the same cycle; no bank traffic; state stays IDLE.
  - REQ: waiting for arbitration or for the handshake. On bank_req_valid & bank_req_ready with bank_req_ch == c -> DONE, and latch done_ptr = ch_r_ptr[c].
  - DONE: hold until ch_r_ptr[c] != done_ptr, then -> IDLE in the same cycle.
- ch_last_entry_already_pop[c] = (state==DONE & ch_r_ptr[c]==done_ptr) | (state==IDLE & pending & ~ch_head_hit[c]).
  - The ptr-match qualifier is mandatory: the flag drops in the same cycle r_ptr changes, so r_ptr never double-advances.
- Arbitration:
  - Round-robin among channels in REQ whose slot is not already selected.
  - The winner is loaded into a single output register; bank_req_valid rises the cycle after selection.
  - Minimum latency: head becomes pending & hit at cycle N -> bank_req_valid at N+1 -> with ready high, pop flag at N+2.
- Output handshake:
  - valid/data/ch/ptr held stable while valid & ~ready.
  - valid never deasserts without a handshake except on rst.
  - The output register reloads in the handshake cycle if another channel is in REQ (back-to-back, one request per cycle).
- RR pointer advances to the channel after the winner on each load.
- Simultaneous events:
  - A channel may transition DONE->IDLE->REQ evaluation in consecutive cycles. The new head is evaluated the cycle after r_ptr changes.
  - A handshake and a new selection in the same cycle are both honoured.
- Reset values (at the first clk edge with rst high; mid-operation reset drops any in-flight request without handshake): all FSMs IDLE, bank_req_valid=0, bank_req_data/ch/ptr=0, RR pointer=0, all pop flags 0 unless driven by the combinational no-hit term.
- Arithmetic: RR index wraps NUM_CH-1 -> 0. Pointer compare is exact PTR_W-bit equality; wrap 7->0 needs no special case.

Optional Feature:
- Macro: XBAR_BANK_POP_PERF_EN.
- Defined: adds output stall_cnt (16 bits) and per-channel output wait_cnt[NUM_CH] (16 bits each), all saturating.
  - stall_cnt increments on valid & ~ready.
  - wait_cnt[c] increments each cycle channel c is in REQ and is not the loaded request.
  - All cleared by rst.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- mpc_types gains XBAR_NUM_CH=3 and XBAR_PTR_W=3.
- mpc_types gains enum xbar_pop_st_e {POP_IDLE, POP_REQ, POP_DONE}.
- mpc_types gains struct xbar_bank_req_t {data, ch, ptr}.
- Sub-module xbar_rr_arb (NUM_CH requests, one-hot grant, rotating priority, advance-enable input) is natural and reusable across the four banks.

Test Plan:
- Single request, ready high: ch0 w_ptr 0->1 with hit=1 at cycle 10 -> bank_req_valid at cycle 11 (ch=0, ptr=0); pop[0] high at 12. Drive r_ptr 0->1 at 14 -> pop[0] low at 14 (same cycle), FSM IDLE.
- No-hit entry: ch1 w_ptr=1, r_ptr=0, hit=0 -> pop[1] high the same cycle; no bank_req_valid ever. r_ptr->1 -> pop[1] low.
- Round-robin under contention: all 3 channels pending and hit simultaneously, ready high -> grants in order ch0, ch1, ch2 on consecutive cycles; repeated fill -> ch0 again (no starvation).
- Backpressure: ready low for 5 cycles with valid high -> data/ch/ptr stable all 5 cycles, no pop; ready high -> pop next cycle.
- Wrap-around: ch2 streams 10 entries, r_ptr 7->0 -> each slot issued exactly once; bank_req_ptr sequence 0..7,0,1.
- Reset mid-operation: rst high while valid & ~ready -> next cycle valid=0, all pops 0 (no-hit term aside), RR restarts at ch0.
